// File: rtl/alu_ctrl_branch_clkdiv.sv
// Execute-stage helper: ALU command decoder, branch-taken gate and an even-ratio clock divider.
// Decode and gate are combinational; only the divider holds state.
module alu_ctrl_branch_clkdiv #(
    parameter int unsigned DIVISOR = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_alu_op,
    input  logic [6:0] i_func7,
    input  logic [2:0] i_func3,
    output logic [3:0] o_alu_ctrl,
    output logic       o_illegal,
    input  logic       i_zero,
    input  logic       i_branch,
    output logic       o_pc_sel,
    output logic       o_clk_div,
    output logic       o_div_tick
);

    localparam logic [3:0] AluAnd  = 4'b0000;
    localparam logic [3:0] AluOr   = 4'b0001;
    localparam logic [3:0] AluAdd  = 4'b0010;
    localparam logic [3:0] AluXor  = 4'b0011;
    localparam logic [3:0] AluSll  = 4'b0100;
    localparam logic [3:0] AluSrl  = 4'b0101;
    localparam logic [3:0] AluSub  = 4'b0110;
    localparam logic [3:0] AluSlt  = 4'b0111;
    localparam logic [3:0] AluSltu = 4'b1000;
    localparam logic [3:0] AluSra  = 4'b1001;
    localparam logic [3:0] AluIll  = 4'b1111;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    logic w_f7_base;
    logic w_f7_alt;

    assign w_f7_base = (i_func7 == F7Base);
    assign w_f7_alt  = (i_func7 == F7Alt);

    // Anything not explicitly matched falls through to the illegal code.
    always_comb begin
        o_alu_ctrl = AluIll;
        unique case (i_alu_op)
            2'b00: o_alu_ctrl = AluAdd;
            2'b01: o_alu_ctrl = AluSub;
            2'b10: begin
                case (i_func3)
                    3'b000: begin
                        if (w_f7_base)     o_alu_ctrl = AluAdd;
                        else if (w_f7_alt) o_alu_ctrl = AluSub;
                    end
                    3'b001:  if (w_f7_base) o_alu_ctrl = AluSll;
                    3'b010:  if (w_f7_base) o_alu_ctrl = AluSlt;
                    3'b011:  if (w_f7_base) o_alu_ctrl = AluSltu;
                    3'b100:  if (w_f7_base) o_alu_ctrl = AluXor;
                    3'b101: begin
                        if (w_f7_base)     o_alu_ctrl = AluSrl;
                        else if (w_f7_alt) o_alu_ctrl = AluSra;
                    end
                    3'b110:  if (w_f7_base) o_alu_ctrl = AluOr;
                    3'b111:  if (w_f7_base) o_alu_ctrl = AluAnd;
                    default: o_alu_ctrl = AluIll;
                endcase
            end
            2'b11: begin
                // Immediate forms: func7 only qualifies the shift encodings.
                case (i_func3)
                    3'b000:  o_alu_ctrl = AluAdd;
                    3'b001:  if (w_f7_base) o_alu_ctrl = AluSll;
                    3'b010:  o_alu_ctrl = AluSlt;
                    3'b011:  o_alu_ctrl = AluSltu;
                    3'b100:  o_alu_ctrl = AluXor;
                    3'b101: begin
                        if (w_f7_base)     o_alu_ctrl = AluSrl;
                        else if (w_f7_alt) o_alu_ctrl = AluSra;
                    end
                    3'b110:  o_alu_ctrl = AluOr;
                    3'b111:  o_alu_ctrl = AluAnd;
                    default: o_alu_ctrl = AluIll;
                endcase
            end
            default: o_alu_ctrl = AluIll;
        endcase
    end

    assign o_illegal = (o_alu_ctrl == AluIll);
    assign o_pc_sel  = i_zero & i_branch;

    localparam int unsigned Half = DIVISOR / 2;
    localparam int unsigned CntW = (Half > 1) ? $clog2(Half) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(Half - 1);

    logic [CntW-1:0] r_cnt;
    logic            r_clk_div;
    logic            r_div_tick;
    logic            w_wrap;

    assign w_wrap = (r_cnt == CntLast);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cnt      <= '0;
            r_clk_div  <= 1'b0;
            r_div_tick <= 1'b0;
        end else begin
            // Tick lands together with the 0->1 transition of the divided clock.
            r_div_tick <= w_wrap & ~r_clk_div;
            if (w_wrap) begin
                r_cnt     <= '0;
                r_clk_div <= ~r_clk_div;
            end else begin
                r_cnt <= r_cnt + CntW'(1);
            end
        end
    end

    assign o_clk_div  = r_clk_div;
    assign o_div_tick = r_div_tick;

endmodule

// File: tb/tb_alu_ctrl_branch_clkdiv.sv
// Scoreboard bench: stimulus pushes expected values from a reference model, a negedge monitor
// pops and compares against two divider ratios (4 and 2) sharing the same inputs.
module tb_alu_ctrl_branch_clkdiv;

    logic       clk;
    logic       reset;
    logic [1:0] alu_op;
    logic [6:0] func7;
    logic [2:0] func3;
    logic       zero;
    logic       branch;
    logic [3:0] alu_ctrl;
    logic       illegal;
    logic       pc_sel;
    logic       clk_div;
    logic       div_tick;
    logic [3:0] alu_ctrl2;
    logic       illegal2;
    logic       pc_sel2;
    logic       clk_div2;
    logic       div_tick2;

    alu_ctrl_branch_clkdiv #(.DIVISOR(4)) u_dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_alu_op   (alu_op),
        .i_func7    (func7),
        .i_func3    (func3),
        .o_alu_ctrl (alu_ctrl),
        .o_illegal  (illegal),
        .i_zero     (zero),
        .i_branch   (branch),
        .o_pc_sel   (pc_sel),
        .o_clk_div  (clk_div),
        .o_div_tick (div_tick)
    );

    alu_ctrl_branch_clkdiv #(.DIVISOR(2)) u_dut2 (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_alu_op   (alu_op),
        .i_func7    (func7),
        .i_func3    (func3),
        .o_alu_ctrl (alu_ctrl2),
        .o_illegal  (illegal2),
        .i_zero     (zero),
        .i_branch   (branch),
        .o_pc_sel   (pc_sel2),
        .o_clk_div  (clk_div2),
        .o_div_tick (div_tick2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ctrl;
        logic       ill;
        logic       pc;
        logic       cd;
        logic       tk;
        logic       cd2;
        logic       tk2;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Legal R-type encodings as {func7, func3, command}; shift immediates reuse these rows.
    logic [13:0] r_tab [10];
    logic [3:0]  i_tab [8];

    function automatic void ref_dec(input logic [1:0] op, input logic [6:0] f7,
                                    input logic [2:0] f3, output logic [3:0] c,
                                    output logic il);
        c = 4'b1111;
        if (op == 2'b00) c = 4'b0010;
        else if (op == 2'b01) c = 4'b0110;
        else if (op == 2'b10 || f3 == 3'd1 || f3 == 3'd5) begin
            for (int k = 0; k < 10; k++)
                if (r_tab[k][13:4] == {f7, f3}) c = r_tab[k][3:0];
        end else begin
            c = i_tab[f3];
        end
        il = (c == 4'b1111);
    endfunction

    // Edge n after reset release: divided clock is (n / (D/2)) mod 2, tick where n mod D == D/2.
    function automatic void ref_div(input int n, input int d, output logic cd, output logic tk);
        cd = ((n / (d / 2)) % 2) == 1;
        tk = (n != 0) && ((n % d) == (d / 2));
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("alu_ctrl", alu_ctrl, e.ctrl);
            check("illegal", {3'b0, illegal}, {3'b0, e.ill});
            check("pc_sel", {3'b0, pc_sel}, {3'b0, e.pc});
            check("clk_div", {3'b0, clk_div}, {3'b0, e.cd});
            check("div_tick", {3'b0, div_tick}, {3'b0, e.tk});
            check("clk_div_d2", {3'b0, clk_div2}, {3'b0, e.cd2});
            check("div_tick_d2", {3'b0, div_tick2}, {3'b0, e.tk2});
        end
    end

    logic [1:0] d_op [12];
    logic [6:0] d_f7 [12];
    logic [2:0] d_f3 [12];

    initial begin
        int   n;
        int   mid_hold;
        bit   mid_done;
        exp_t e;

        r_tab[0] = {7'h00, 3'd0, 4'b0010};
        r_tab[1] = {7'h20, 3'd0, 4'b0110};
        r_tab[2] = {7'h00, 3'd1, 4'b0100};
        r_tab[3] = {7'h00, 3'd2, 4'b0111};
        r_tab[4] = {7'h00, 3'd3, 4'b1000};
        r_tab[5] = {7'h00, 3'd4, 4'b0011};
        r_tab[6] = {7'h00, 3'd5, 4'b0101};
        r_tab[7] = {7'h20, 3'd5, 4'b1001};
        r_tab[8] = {7'h00, 3'd6, 4'b0001};
        r_tab[9] = {7'h00, 3'd7, 4'b0000};
        i_tab[0] = 4'b0010; i_tab[1] = 4'b1111; i_tab[2] = 4'b0111; i_tab[3] = 4'b1000;
        i_tab[4] = 4'b0011; i_tab[5] = 4'b1111; i_tab[6] = 4'b0001; i_tab[7] = 4'b0000;

        d_op[0]  = 2'b10; d_f7[0]  = 7'h00; d_f3[0]  = 3'd0;
        d_op[1]  = 2'b10; d_f7[1]  = 7'h20; d_f3[1]  = 3'd0;
        d_op[2]  = 2'b10; d_f7[2]  = 7'h00; d_f3[2]  = 3'd7;
        d_op[3]  = 2'b10; d_f7[3]  = 7'h00; d_f3[3]  = 3'd6;
        d_op[4]  = 2'b10; d_f7[4]  = 7'h20; d_f3[4]  = 3'd5;
        d_op[5]  = 2'b10; d_f7[5]  = 7'h20; d_f3[5]  = 3'd7;
        d_op[6]  = 2'b11; d_f7[6]  = 7'h7f; d_f3[6]  = 3'd0;
        d_op[7]  = 2'b11; d_f7[7]  = 7'h20; d_f3[7]  = 3'd5;
        d_op[8]  = 2'b11; d_f7[8]  = 7'h20; d_f3[8]  = 3'd1;
        d_op[9]  = 2'b00; d_f7[9]  = 7'h55; d_f3[9]  = 3'd3;
        d_op[10] = 2'b01; d_f7[10] = 7'h7f; d_f3[10] = 3'd7;
        d_op[11] = 2'b11; d_f7[11] = 7'h00; d_f3[11] = 3'd1;

        reset = 1'b0; alu_op = 2'b00; func7 = '0; func3 = '0; zero = 1'b0; branch = 1'b0;
        n = 0; mid_hold = 0; mid_done = 1'b0;

        for (int c = 0; c < 240; c++) begin
            @(posedge clk);
            n = reset ? n + 1 : 0;
            #1;
            if (c == 0) reset = 1'b0;
            else if (n == 15 && !mid_done) begin
                // Divided clock high with the counter at its last value.
                reset = 1'b0; mid_done = 1'b1; mid_hold = 1;
            end else if (mid_hold > 0) begin
                reset = 1'b0; mid_hold--;
            end else if (c > 60 && $urandom_range(39) == 0) reset = 1'b0;
            else reset = 1'b1;

            if (c < 12) begin
                alu_op = d_op[c]; func7 = d_f7[c]; func3 = d_f3[c];
                zero = c[0]; branch = c[1];
            end else begin
                alu_op = 2'($urandom_range(3));
                case ($urandom_range(3))
                    0:       func7 = 7'h00;
                    1:       func7 = 7'h20;
                    default: func7 = 7'($urandom_range(127));
                endcase
                func3  = 3'($urandom_range(7));
                zero   = 1'($urandom_range(1));
                branch = 1'($urandom_range(1));
            end

            ref_dec(alu_op, func7, func3, e.ctrl, e.ill);
            e.pc = zero && branch;
            ref_div(n, 4, e.cd, e.tk);
            ref_div(n, 2, e.cd2, e.tk2);
            sb_q.push_back(e);
        end

        repeat (4) @(negedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_branch_clkdiv.md
# alu_ctrl_branch_clkdiv

Execute-stage support block for the 5-stage RV32I pipeline. It combines three functions: the ALU-operation decoder that turns the ID/EX `ALUOp` plus funct7/funct3 into a 4-bit ALU command, the branch-taken gate feeding the PC-select mux from EX/MEM, and the clock divider that produces the slow clock driving the LED read-address counter. Decoding and branch gating are purely combinational; only the divider holds state.

## Interface
- `DIVISOR`, default 4: divide ratio of `clk_div`; must be even and ≥ 2.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-low reset (0 = reset).
- `alu_op`  input  2  ALUOp from ID/EX.
- `func7`  input  7  instruction[31:25] from ID/EX.
- `func3`  input  3  instruction[14:12] from ID/EX.
- `alu_ctrl`  output  4  ALU command.
- `illegal`  output  1  high when the funct combination is not supported.
- `zero`  input  1  EX/MEM ALU zero flag.
- `branch`  input  1  EX/MEM branch control.
- `pc_sel`  output  1  1 = take branch target.
- `clk_div`  output  1  divided clock, registered, 50 % duty.
- `div_tick`  output  1  one-`clk` pulse on each rising transition of `clk_div`.

## Operation
- ALU command codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SLTU 1000, SRA 1001, ILLEGAL 1111.
- `alu_op` = 00 (load/store): ADD. Funct fields are ignored and `illegal` = 0.
- `alu_op` = 01 (branch): SUB. Funct fields are ignored and `illegal` = 0.
- `alu_op` = 10 (R-type), keyed on func3 and func7:
  - func3 000: func7 0000000 gives ADD; func7 0100000 gives SUB.
  - func3 001 with func7 0000000: SLL.
  - func3 010 with func7 0000000: SLT.
  - func3 011 with func7 0000000: SLTU.
  - func3 100 with func7 0000000: XOR.
  - func3 101: func7 0000000 gives SRL; func7 0100000 gives SRA.
  - func3 110 with func7 0000000: OR.
  - func3 111 with func7 0000000: AND.
- `alu_op` = 11 (I-type ALU), keyed on func3; func7 is checked only for shifts:
  - 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - 001 SLL when func7 = 0000000.
  - 101: SRL when func7 = 0000000; SRA when func7 = 0100000.
- Any other combination: `alu_ctrl` = 1111 and `illegal` = 1. In every other case `illegal` = 0.
- `pc_sel` = `zero` AND `branch`.
- Decoder and gate are independent of `clk` and `reset`; their outputs stay valid during reset.
- Divider state: counter `cnt` of width clog2(DIVISOR/2), minimum 1 bit, plus the `clk_div` register.
  - Each rising edge with `reset` = 1: if `cnt` = DIVISOR/2−1, then `cnt` ← 0 and `clk_div` toggles; otherwise `cnt` increments.
  - `div_tick` is registered: it is 1 in the cycle after the edge where `clk_div` went 0→1, and 0 otherwise.

## Timing
- `alu_ctrl`, `illegal` and `pc_sel` have zero-cycle (combinational) latency.
- Reset: at a rising edge with `reset` = 0, `cnt` = 0, `clk_div` = 0 and `div_tick` = 0.
- Reset asserted mid-count: these values are forced on the next edge regardless of the current phase.
- DIVISOR = 4, counting edges after reset is released:
  - `clk_div` sequence is 0,1,1,0,0,1,1,… (period 4 `clk`, high 2 / low 2).
  - `div_tick` is high at edges 2, 6, 10, …
- DIVISOR = 2: `clk_div` toggles on every edge.
- Wrap-around: `cnt` returns to 0 on the same edge that `clk_div` toggles, with no skipped or extra cycles.

## Test plan
- `alu_op` 00 and 01 with random funct fields → `alu_ctrl` 0010 / 0110 respectively, `illegal` 0.
- `alu_op` 10 sweep:
  - (0000000,000) → 0010; (0100000,000) → 0110; (0000000,111) → 0000; (0000000,110) → 0001; (0100000,101) → 1001.
  - (0100000,111) → 1111 with `illegal` 1.
- `alu_op` 11:
  - func3 000 with func7 1111111 → 0010.
  - func3 101 with func7 0100000 → 1001.
  - func3 001 with func7 0100000 → 1111 with `illegal` 1.
- `zero`/`branch` all four combinations → `pc_sel` high only for 1/1.
- `reset` low for 2 edges, then high for 12 edges (DIVISOR = 4):
  - During reset, `clk_div` and `div_tick` are 0.
  - After release, `clk_div` follows 0,1,1,0,0,1,1,0,0,1,1,0.
  - `div_tick` is high only at edges 2, 6, 10.
- Assert `reset` when `clk_div` = 1 and `cnt` = 1:
  - Next edge forces `clk_div` = 0.
  - After release the sequence restarts identically to the previous scenario.
